// File: rtl/multiplicador_pkg.sv
// Shared types and sizing helpers for the radix-4 Booth multiplier.
// FSM encodings, Booth digit layout and extended-width functions.
package multiplicador_pkg;

  typedef enum logic [1:0] {
    IDLE,
    CALC,
    DONE
  } estado_t;

  typedef struct packed {
    logic cero;
    logic doble;
    logic neg;
  } booth_digit_t;

  // E = 2*ceil((n+1)/2): room for the sign/zero extension bit
  function automatic int ancho_ext(input int n);
    return 2 * ((n + 2) / 2);
  endfunction

  function automatic int num_iter(input int n);
    return ancho_ext(n) / 2;
  endfunction

endpackage

// File: rtl/booth_r4_codificador.sv
// Radix-4 Booth recoder: 3-bit multiplier window to {cero, doble, neg}.
// Purely combinational.
module booth_r4_codificador
  import multiplicador_pkg::*;
(
  input  logic [2:0]   ventana,
  output booth_digit_t digito
);

  always_comb begin
    digito = '{cero: 1'b1, doble: 1'b0, neg: 1'b0};
    unique case (ventana)
      3'b000: digito = '{cero: 1'b1, doble: 1'b0, neg: 1'b0};
      3'b001: digito = '{cero: 1'b0, doble: 1'b0, neg: 1'b0};
      3'b010: digito = '{cero: 1'b0, doble: 1'b0, neg: 1'b0};
      3'b011: digito = '{cero: 1'b0, doble: 1'b1, neg: 1'b0};
      3'b100: digito = '{cero: 1'b0, doble: 1'b1, neg: 1'b1};
      3'b101: digito = '{cero: 1'b0, doble: 1'b0, neg: 1'b1};
      3'b110: digito = '{cero: 1'b0, doble: 1'b0, neg: 1'b1};
      3'b111: digito = '{cero: 1'b1, doble: 1'b0, neg: 1'b0};
    endcase
  end

endmodule

// File: rtl/multiplicador_booth_r4.sv
// Sequential radix-4 Booth multiplier, signed or unsigned at runtime.
// Two multiplier bits retired per cycle; start/fin handshake.
module multiplicador_booth_r4
  import multiplicador_pkg::*;
#(
  parameter int NUM_BITS = 8
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  start,
  input  logic                  signo,
  input  logic [NUM_BITS-1:0]   multiplicando,
  input  logic [NUM_BITS-1:0]   multiplicador,
  output logic [2*NUM_BITS-1:0] resultado,
  output logic                  fin,
  output logic                  ocupado
);

  localparam int E  = ancho_ext(NUM_BITS);
  localparam int K  = num_iter(NUM_BITS);
  localparam int A  = E + 2;
  localparam int CW = $clog2(K + 1);

  estado_t               state_q, state_d;
  logic [A-1:0]          acc_q, acc_d;
  logic [A-1:0]          m_q, m_d;
  logic [E-1:0]          q_q, q_d;
  logic                  qm1_q, qm1_d;
  logic [CW-1:0]         cnt_q, cnt_d;
  logic [2*NUM_BITS-1:0] res_q, res_d;
  logic                  fin_q, fin_d;
  logic                  ocu_q, ocu_d;

  booth_digit_t digito;
  logic [A-1:0] mult, addend, sum, acc_sh;
  logic [E-1:0] q_sh;
  logic [A+E-1:0] prod;

  booth_r4_codificador u_cod (
    .ventana ({q_q[1], q_q[0], qm1_q}),
    .digito  (digito)
  );

  always_comb begin
    mult   = digito.doble ? {m_q[A-2:0], 1'b0} : m_q;
    addend = digito.cero ? '0 : (digito.neg ? (~mult + 1'b1) : mult);
    sum    = acc_q + addend;
    acc_sh = {{2{sum[A-1]}}, sum[A-1:2]};
    q_sh   = {sum[1:0], q_q[E-1:2]};
    prod   = {acc_sh, q_sh};
  end

  always_comb begin
    state_d = state_q;
    acc_d   = acc_q;
    m_d     = m_q;
    q_d     = q_q;
    qm1_d   = qm1_q;
    cnt_d   = cnt_q;
    res_d   = res_q;
    unique case (state_q)
      IDLE: begin
        if (start) begin
          m_d = {{(A-NUM_BITS){signo & multiplicando[NUM_BITS-1]}},
                 multiplicando};
          q_d = {{(E-NUM_BITS){signo & multiplicador[NUM_BITS-1]}},
                 multiplicador};
          qm1_d   = 1'b0;
          acc_d   = '0;
          cnt_d   = '0;
          state_d = CALC;
        end
      end
      CALC: begin
        acc_d = acc_sh;
        q_d   = q_sh;
        qm1_d = q_q[1];
        cnt_d = cnt_q + CW'(1);
        if (cnt_q == CW'(K - 1)) begin
          res_d   = prod[2*NUM_BITS-1:0];
          state_d = DONE;
        end
      end
      DONE:    state_d = IDLE;
      default: state_d = IDLE;
    endcase
    fin_d = (state_d == DONE);
    ocu_d = (state_d != IDLE);
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q <= IDLE;
      acc_q   <= '0;
      m_q     <= '0;
      q_q     <= '0;
      qm1_q   <= 1'b0;
      cnt_q   <= '0;
      res_q   <= '0;
      fin_q   <= 1'b0;
      ocu_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      acc_q   <= acc_d;
      m_q     <= m_d;
      q_q     <= q_d;
      qm1_q   <= qm1_d;
      cnt_q   <= cnt_d;
      res_q   <= res_d;
      fin_q   <= fin_d;
      ocu_q   <= ocu_d;
    end
  end

  assign resultado = res_q;
  assign fin       = fin_q;
  assign ocupado   = ocu_q;

endmodule

// File: tb/tb_multiplicador_booth_r4.sv
// Directed and exhaustive bench for multiplicador_booth_r4.
// Instances at NUM_BITS 4, 5 and 8 share clock, reset and mode.
module tb_multiplicador_booth_r4;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        signo;
  logic        start4, start5, start8;
  logic [3:0]  mc4, mq4;
  logic [4:0]  mc5, mq5;
  logic [7:0]  mc8, mq8;
  logic [7:0]  res4;
  logic [9:0]  res5;
  logic [15:0] res8;
  logic        fin4, fin5, fin8;
  logic        ocu4, ocu5, ocu8;

  int checks = 0;
  int failures = 0;

  always #5 clk = ~clk;

  multiplicador_booth_r4 #(.NUM_BITS(4)) dut4 (
    .clk(clk), .rst_n(rst_n), .start(start4), .signo(signo),
    .multiplicando(mc4), .multiplicador(mq4),
    .resultado(res4), .fin(fin4), .ocupado(ocu4)
  );

  multiplicador_booth_r4 #(.NUM_BITS(5)) dut5 (
    .clk(clk), .rst_n(rst_n), .start(start5), .signo(signo),
    .multiplicando(mc5), .multiplicador(mq5),
    .resultado(res5), .fin(fin5), .ocupado(ocu5)
  );

  multiplicador_booth_r4 #(.NUM_BITS(8)) dut8 (
    .clk(clk), .rst_n(rst_n), .start(start8), .signo(signo),
    .multiplicando(mc8), .multiplicador(mq8),
    .resultado(res8), .fin(fin8), .ocupado(ocu8)
  );

  task automatic run4(input logic [3:0] m, input logic [3:0] q,
                      input logic s, output logic [7:0] r,
                      output int lat);
    @(negedge clk);
    mc4 = m; mq4 = q; signo = s; start4 = 1'b1;
    @(negedge clk);
    start4 = 1'b0;
    lat = 0;
    while (!fin4 && lat < 20) begin
      @(negedge clk);
      lat++;
    end
    r = res4;
  endtask

  task automatic run5(input logic [4:0] m, input logic [4:0] q,
                      input logic s, output logic [9:0] r,
                      output int lat);
    @(negedge clk);
    mc5 = m; mq5 = q; signo = s; start5 = 1'b1;
    @(negedge clk);
    start5 = 1'b0;
    lat = 0;
    while (!fin5 && lat < 20) begin
      @(negedge clk);
      lat++;
    end
    r = res5;
  endtask

  task automatic run8(input logic [7:0] m, input logic [7:0] q,
                      input logic s, output logic [15:0] r,
                      output int lat);
    @(negedge clk);
    mc8 = m; mq8 = q; signo = s; start8 = 1'b1;
    @(negedge clk);
    start8 = 1'b0;
    lat = 0;
    while (!fin8 && lat < 20) begin
      @(negedge clk);
      lat++;
    end
    r = res8;
  endtask

  task automatic test_reset();
    int lat;
    rst_n = 1'b0; start4 = 1'b1; mc4 = 4'd2; mq4 = 4'd3; signo = 1'b1;
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      checks++;
      if (res4 !== 8'h00 || fin4 !== 1'b0 || ocu4 !== 1'b0) begin
        failures++;
        $display("FAIL reset_hold cyc=%0d got res=%h fin=%b ocu=%b exp 00/0/0",
                 i, res4, fin4, ocu4);
      end
    end
    rst_n = 1'b1;
    @(negedge clk);
    checks++;
    if (ocu4 !== 1'b1) begin
      failures++;
      $display("FAIL reset_pending_start got ocupado=%b exp 1", ocu4);
    end
    start4 = 1'b0;
    lat = 0;
    while (!fin4 && lat < 20) begin
      @(negedge clk);
      lat++;
    end
    checks++;
    if (res4 !== 8'h06 || lat != 3) begin
      failures++;
      $display("FAIL reset_first_op got res=%h lat=%0d exp 06 lat=3", res4, lat);
    end
  endtask

  task automatic test_signed();
    logic [7:0] r;
    int lat;
    run4(4'h8, 4'h8, 1'b1, r, lat);
    checks++;
    if (r !== 8'h40) begin
      failures++;
      $display("FAIL signed_m8xm8 got %h exp 40", r);
    end
    checks++;
    if (lat != 3) begin
      failures++;
      $display("FAIL signed_latency got %0d exp 3", lat);
    end
    run4(4'h8, 4'h7, 1'b1, r, lat);
    checks++;
    if (r !== 8'hC8) begin
      failures++;
      $display("FAIL signed_m8x7 got %h exp c8", r);
    end
  endtask

  task automatic test_unsigned();
    logic [7:0] r;
    int lat;
    run4(4'hF, 4'hF, 1'b0, r, lat);
    checks++;
    if (r !== 8'hE1) begin
      failures++;
      $display("FAIL unsigned_15x15 got %h exp e1", r);
    end
    run4(4'hF, 4'h0, 1'b0, r, lat);
    checks++;
    if (r !== 8'h00) begin
      failures++;
      $display("FAIL unsigned_15x0 got %h exp 00", r);
    end
    run4(4'hF, 4'hF, 1'b1, r, lat);
    checks++;
    if (r !== 8'h01) begin
      failures++;
      $display("FAIL signed_m1xm1 got %h exp 01", r);
    end
    run4(4'hF, 4'h0, 1'b1, r, lat);
    checks++;
    if (r !== 8'h00) begin
      failures++;
      $display("FAIL signed_m1x0 got %h exp 00", r);
    end
  endtask

  task automatic test_back_to_back();
    logic ef, eo;
    @(negedge clk);
    mc4 = 4'd3; mq4 = 4'hE; signo = 1'b1; start4 = 1'b1;
    @(negedge clk);
    for (int i = 0; i < 15; i++) begin
      ef = ((i % 5) == 3);
      eo = ((i % 5) != 4);
      checks++;
      if (fin4 !== ef || ocu4 !== eo) begin
        failures++;
        $display("FAIL b2b_handshake i=%0d got fin=%b ocu=%b exp fin=%b ocu=%b",
                 i, fin4, ocu4, ef, eo);
      end
      if (ef) begin
        checks++;
        if (res4 !== 8'hFA) begin
          failures++;
          $display("FAIL b2b_result i=%0d got %h exp fa", i, res4);
        end
      end
      if (i < 14) @(negedge clk);
    end
    start4 = 1'b0;
  endtask

  task automatic test_operand_change();
    int lat;
    @(negedge clk);
    mc4 = 4'd5; mq4 = 4'hD; signo = 1'b1; start4 = 1'b1;
    @(negedge clk);
    start4 = 1'b0; mc4 = 4'd7; mq4 = 4'd7; signo = 1'b0;
    lat = 0;
    while (!fin4 && lat < 20) begin
      @(negedge clk);
      lat++;
    end
    checks++;
    if (res4 !== 8'hF1 || lat != 3) begin
      failures++;
      $display("FAIL operand_change got res=%h lat=%0d exp f1 lat=3", res4, lat);
    end
  endtask

  task automatic test_reset_mid();
    logic [7:0] r;
    int lat;
    int nfin;
    @(negedge clk);
    mc4 = 4'd6; mq4 = 4'd5; signo = 1'b0; start4 = 1'b1;
    @(negedge clk);
    start4 = 1'b0;
    @(negedge clk);
    rst_n = 1'b0;
    @(negedge clk);
    checks++;
    if (res4 !== 8'h00 || fin4 !== 1'b0 || ocu4 !== 1'b0) begin
      failures++;
      $display("FAIL reset_mid got res=%h fin=%b ocu=%b exp 00/0/0",
               res4, fin4, ocu4);
    end
    rst_n = 1'b1;
    nfin = 0;
    for (int i = 0; i < 8; i++) begin
      @(negedge clk);
      if (fin4 === 1'b1) nfin++;
    end
    checks++;
    if (nfin != 0) begin
      failures++;
      $display("FAIL reset_mid_nofin got %0d fin pulses exp 0", nfin);
    end
    run4(4'd6, 4'd5, 1'b0, r, lat);
    checks++;
    if (r !== 8'h1E || lat != 3) begin
      failures++;
      $display("FAIL reset_mid_after got res=%h lat=%0d exp 1e lat=3", r, lat);
    end
  endtask

  task automatic test_exhaustive4();
    logic [7:0] r, e;
    int lat, a, b;
    for (int s = 0; s < 2; s++)
      for (int mi = 0; mi < 16; mi++)
        for (int qi = 0; qi < 16; qi++) begin
          run4(4'(mi), 4'(qi), 1'(s), r, lat);
          a = (s == 1 && mi >= 8) ? mi - 16 : mi;
          b = (s == 1 && qi >= 8) ? qi - 16 : qi;
          e = 8'(a * b);
          checks++;
          if (r !== e || lat != 3) begin
            failures++;
            $display("FAIL exh4 s=%0d m=%0d q=%0d got %h lat=%0d exp %h lat=3",
                     s, mi, qi, r, lat, e);
          end
        end
  endtask

  task automatic test_exhaustive5();
    logic [9:0] r, e;
    int lat, a, b;
    for (int s = 0; s < 2; s++)
      for (int mi = 0; mi < 32; mi++)
        for (int qi = 0; qi < 32; qi++) begin
          run5(5'(mi), 5'(qi), 1'(s), r, lat);
          a = (s == 1 && mi >= 16) ? mi - 32 : mi;
          b = (s == 1 && qi >= 16) ? qi - 32 : qi;
          e = 10'(a * b);
          checks++;
          if (r !== e || lat != 3) begin
            failures++;
            $display("FAIL exh5 s=%0d m=%0d q=%0d got %h lat=%0d exp %h lat=3",
                     s, mi, qi, r, lat, e);
          end
        end
  endtask

  task automatic test_random8();
    logic [15:0] r, e;
    int lat, a, b, mi, qi, s;
    for (int n = 0; n < 1000; n++) begin
      if (n < 4) begin
        mi = (n < 2) ? 128 : 255;
        qi = (n < 2) ? 128 : 255;
        s = n % 2;
      end else begin
        mi = int'($urandom_range(0, 255));
        qi = int'($urandom_range(0, 255));
        s = int'($urandom_range(0, 1));
      end
      run8(8'(mi), 8'(qi), 1'(s), r, lat);
      a = (s == 1 && mi >= 128) ? mi - 256 : mi;
      b = (s == 1 && qi >= 128) ? qi - 256 : qi;
      e = 16'(a * b);
      checks++;
      if (r !== e || lat != 5) begin
        failures++;
        $display("FAIL rnd8 s=%0d m=%0d q=%0d got %h lat=%0d exp %h lat=5",
                 s, mi, qi, r, lat, e);
      end
    end
  endtask

  initial begin
    rst_n = 1'b0;
    signo = 1'b0;
    start4 = 1'b0; start5 = 1'b0; start8 = 1'b0;
    mc4 = '0; mq4 = '0; mc5 = '0; mq5 = '0; mc8 = '0; mq8 = '0;
    test_reset();
    test_signed();
    test_unsigned();
    test_back_to_back();
    test_operand_change();
    test_reset_mid();
    test_exhaustive4();
    test_exhaustive5();
    test_random8();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
